memory_cycle_lsu: RTL and testbench
===================================

# memory_cycle_lsu

Memory-stage load/store unit of the five-stage RISC-V pipeline. It consumes the M-stage control and data bundle registered by the execute stage and runs loads and stores over a req/ack data-memory bus, holding the pipeline with `StallM` while an access is outstanding. It registers the M/W pipeline boundary and drives the writeback result `ResultW`, which feeds the execute-stage forwarding muxes.

## Interface
- `TIMEOUT`, default 16: maximum cycles in REQ without `mem_ack` before the access is abandoned. Legal range is 1–255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `RegWriteM`, `MemWriteM`, `ResultSrcM` in 1 each: M-stage controls. `ResultSrcM=1` means load.
- `RD_M` in 5: destination register.
- `PCPlus4M`, `WriteDataM`, `ALU_ResultM` in 32 each: M-stage data. `ALU_ResultM` is the memory address.
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: 1 means store, 0 means load. Valid while `mem_req=1`.
- `mem_addr`, `mem_wdata` out 32 each: latched address and store data.
- `mem_ack` in 1: the access completes in any cycle where `mem_req & mem_ack`.
- `mem_rdata` in 32: load data. Valid when `mem_ack=1`.
- `StallM` out 1: 1 means the IF/ID/E/M stage registers must hold.
- `BusErr` out 1: sticky timeout flag. Cleared only by reset.
- `RegWriteW`, `ResultSrcW` out 1 each; `RD_W` out 5; `PCPlus4W`, `ALU_ResultW`, `ReadDataW` out 32 each: W-stage registers.
- `ResultW` out 32: `ResultSrcW ? ReadDataW : ALU_ResultW`, combinational.

## Operation
- Access needed: `acc = MemWriteM | ResultSrcM`. If both are set, it is treated as a store.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If `acc`: latch `mem_addr=ALU_ResultM`, `mem_wdata=WriteDataM`, `mem_we=MemWriteM`. Set `mem_req=1`, clear the wait counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - If `mem_ack`: capture `mem_rdata` into an internal read-data register (the value is kept for stores but not used), drop `mem_req`, go to DONE.
  - Else if the wait counter is `TIMEOUT-1`: drop `mem_req`, set `BusErr`, set read data to 0, go to DONE.
  - Otherwise increment the wait counter.
- DONE: go to IDLE unconditionally. The M-stage inputs still hold the same instruction, because it was stalled.
- `StallM = (IDLE & acc) | REQ`, combinational. It is 0 in DONE.
- W register update, every clock edge:
  - If `StallM=1`: load a bubble. `RegWriteW=0`, `ResultSrcW=0`, `RD_W=0`, data fields 0.
  - Else: load the M bundle. `ReadDataW` gets the captured read data in DONE, otherwise 0.
- Stores never assert `RegWriteW` unless `RegWriteM` was set. The block passes `RegWriteM` through and does not check it.
- `mem_addr`, `mem_wdata`, `mem_we` stay stable from the req rising edge until the access completes. They keep their last value afterwards.

## Timing
- Non-memory instruction: 1 cycle in M, no stall. It appears in W one edge later.
- Memory op with zero-wait ack:
  - Cycle t: IDLE, `StallM=1`.
  - Cycle t+1: REQ, `mem_req=1`, `mem_ack=1`, `StallM=1`.
  - Cycle t+2: DONE, `StallM=0`.
  - W is valid from t+3.
  - The op holds M for 3 cycles. Each wait cycle adds 1.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then DONE.
- `mem_ack` while `mem_req=0` is ignored.
- Back-to-back memory ops: DONE → IDLE with the next op → REQ. `mem_req` is low for at least 1 cycle between accesses.
- Reset values: every output register is 0, including `mem_*`, `BusErr` and all W fields. State is IDLE. Hence `ResultW=0` and `StallM=acc`.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronously). Any in-flight ack is lost and no W update occurs.

## Test plan
- Reset with `acc=0`, then ALU op `RD_M=5`, `ALU_ResultM=0x1234`, `RegWriteM=1` → next edge `RD_W=5`, `ResultW=0x1234`, `StallM` never 1.
- Load, `ALU_ResultM=0x100`, ack in the first REQ cycle with `mem_rdata=0xDEADBEEF` → `mem_req` high 1 cycle, `mem_addr=0x100`, `mem_we=0`, `StallM` high 2 cycles, then `ResultW=0xDEADBEEF`, `RegWriteW=1`.
- Store, `WriteDataM=0xCAFEF00D`, ack after 3 wait cycles → `mem_we=1`, `mem_wdata=0xCAFEF00D`, `mem_req` high 4 cycles, W bubbles while `StallM=1`, then the store bundle appears in W.
- `TIMEOUT=4`, load with no ack → `mem_req` high exactly 4 cycles, `BusErr=1` and stays 1, `ReadDataW=0`. A following load with ack completes normally.
- Two consecutive loads, each acked immediately → `mem_req` pattern 0,1,0,0,1, each load's `ReadDataW` correct, no lost or duplicated W writes.
- `rst` low during REQ → `mem_req=0` at once, all W outputs 0. After release, with the op still in M, the FSM reissues from IDLE.

Source files
------------

// File: rtl/memory_cycle_lsu.sv
// memory_cycle_lsu
//   Memory-stage load/store unit. Issues one req/ack bus access for each load
//   or store in M, stalls the front of the pipeline while the access is in
//   flight, and registers the M/W boundary including the writeback result mux.
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-low reset
//   RegWriteM, MemWriteM,       M-stage controls (ResultSrcM=1 marks a load)
//   ResultSrcM, RD_M
//   PCPlus4M, WriteDataM,       M-stage data; ALU_ResultM is the memory address
//   ALU_ResultM
//   mem_req, mem_we,            data-memory bus request side (registered)
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata          data-memory bus response side
//   StallM                      hold IF/ID/E/M stage registers
//   BusErr                      sticky access-timeout flag
//   RegWriteW, ResultSrcW,      W-stage registers
//   RD_W, PCPlus4W,
//   ALU_ResultW, ReadDataW
//   ResultW                     writeback value, feeds forwarding
module memory_cycle_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        BusErr,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ResultW
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;

  logic        acc;
  logic        stall;

  // A store flag wins when both controls are set; mem_we simply follows MemWriteM.
  assign acc   = MemWriteM | ResultSrcM;
  assign stall = ((state_q == IDLE) && acc) || (state_q == REQ);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d  = ALU_ResultM;
          wdata_d = WriteDataM;
          we_d    = MemWriteM;
          req_d   = 1'b1;
          wait_d  = 8'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (wait_q == LAST_WAIT) begin
          // Abandon the access; the instruction retires with zero read data.
          rdata_d = 32'd0;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wait_q  <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  // ---- M/W pipeline boundary ----
  logic        rw_w_q, rs_w_q;
  logic [4:0]  rd_w_q;
  logic [31:0] pc_w_q, alu_w_q, rd_data_w_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_w_q      <= 1'b0;
      rs_w_q      <= 1'b0;
      rd_w_q      <= 5'd0;
      pc_w_q      <= 32'd0;
      alu_w_q     <= 32'd0;
      rd_data_w_q <= 32'd0;
    end else if (stall) begin
      // Bubble into W while M is held.
      rw_w_q      <= 1'b0;
      rs_w_q      <= 1'b0;
      rd_w_q      <= 5'd0;
      pc_w_q      <= 32'd0;
      alu_w_q     <= 32'd0;
      rd_data_w_q <= 32'd0;
    end else begin
      rw_w_q      <= RegWriteM;
      rs_w_q      <= ResultSrcM;
      rd_w_q      <= RD_M;
      pc_w_q      <= PCPlus4M;
      alu_w_q     <= ALU_ResultM;
      rd_data_w_q <= (state_q == DONE) ? rdata_q : 32'd0;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign StallM      = stall;
  assign BusErr      = berr_q;
  assign RegWriteW   = rw_w_q;
  assign ResultSrcW  = rs_w_q;
  assign RD_W        = rd_w_q;
  assign PCPlus4W    = pc_w_q;
  assign ALU_ResultW = alu_w_q;
  assign ReadDataW   = rd_data_w_q;
  assign ResultW     = rs_w_q ? rd_data_w_q : alu_w_q;

endmodule

// File: tb/tb_memory_cycle_lsu.sv
module tb_memory_cycle_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        StallM, BusErr;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;

  memory_cycle_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .BusErr(BusErr),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdw;
    logic [31:0] res;
  } wexp_t;

  int total = 0;
  int bad   = 0;

  wexp_t sb_q[$];
  bit    mon_en = 0;
  int    mon_mode = 0;  // 0 none, 1 bubble expected next, 2 write expected next

  // memory responder state
  bit          ack_en = 1;
  int          ack_wait = 0;
  logic [31:0] rd_val = 32'd0;
  int          wcnt = 0;
  int          req_cnt = 0;
  int          stall_cnt = 0;
  int          unstable = 0;
  bit          prev_req = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  logic        req_hist[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic wexp_t w_actual();
    wexp_t a;
    a.rw = RegWriteW; a.rs = ResultSrcW; a.rd = RD_W;
    a.pc = PCPlus4W; a.alu = ALU_ResultW; a.rdw = ReadDataW; a.res = ResultW;
    return a;
  endfunction

  // Monitor: the W register is written on every edge where StallM was low,
  // and must hold a bubble after every edge where StallM was high.
  always @(negedge clk) begin
    if (rst && mon_mode == 2) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected_write: got %0h expected none", w_actual());
      end else begin
        chk("w_bundle", 160'(w_actual()), 160'(sb_q.pop_front()));
      end
    end else if (rst && mon_mode == 1) begin
      chk("w_bubble", 160'(w_actual()), 160'd0);
    end
    mon_mode = (!rst || !mon_en) ? 0 : (StallM ? 1 : 2);
  end

  // Memory responder plus bus observers, sampled mid-cycle.
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      req_cnt++;
      if (!prev_req) begin
        cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
      end else if ({mem_addr, mem_wdata, mem_we} !== {cap_addr, cap_wdata, cap_we}) begin
        unstable++;
      end
      mem_ack   = ack_en && (wcnt == ack_wait);
      mem_rdata = mem_ack ? rd_val : 32'h0BAD_F00D;
      wcnt++;
    end else begin
      wcnt    = 0;
      mem_ack = 1'b0;
    end
    if (StallM) stall_cnt++;
    req_hist.push_back(mem_req);
    prev_req = mem_req;
  end

  // Called at posedge+1: present an instruction in M and queue its W result.
  task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] alu,
                       input wexp_t exp);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
    req_cnt = 0; stall_cnt = 0;
    req_hist.delete();
    sb_q.push_back(exp);
  endtask

  // Wait for the edge that moves the M instruction into W; returns at posedge+1.
  task automatic wait_commit();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!StallM) break;
      n++;
      if (n > 60) begin
        total++; bad++;
        $display("FAIL commit_timeout: got StallM=1 for %0d cycles expected release", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic wexp_t mk(input logic rw, input logic rs, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] rdw, input logic [31:0] res);
    wexp_t e;
    e.rw = rw; e.rs = rs; e.rd = rd; e.pc = pc; e.alu = alu; e.rdw = rdw; e.res = res;
    return e;
  endfunction

  initial begin
    logic [31:0] pat;
    rst = 1'b0;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = 0;
    PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0;
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("reset_outputs",
        160'({mem_req, mem_we, mem_addr, mem_wdata, StallM, BusErr, 160'(w_actual())}), 160'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;

    // ALU op: no stall, straight into W.
    drive(1, 0, 0, 5'd5, 32'h0000_0104, 32'h0, 32'h0000_1234,
          mk(1, 0, 5'd5, 32'h0000_0104, 32'h0000_1234, 32'h0, 32'h0000_1234));
    wait_commit();
    chk("alu_stall_cycles", 160'(stall_cnt), 160'd0);
    chk("alu_req_cycles", 160'(req_cnt), 160'd0);

    // Load with zero-wait ack.
    ack_en = 1; ack_wait = 0; rd_val = 32'hDEAD_BEEF;
    drive(1, 0, 1, 5'd6, 32'h0000_0108, 32'h0, 32'h0000_0100,
          mk(1, 1, 5'd6, 32'h0000_0108, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    wait_commit();
    chk("load_req_cycles", 160'(req_cnt), 160'd1);
    chk("load_stall_cycles", 160'(stall_cnt), 160'd2);
    chk("load_addr_we", 160'({cap_addr, cap_we}), 160'({32'h0000_0100, 1'b0}));

    // Store acked after 3 wait cycles.
    ack_wait = 3; rd_val = 32'h55AA_55AA;
    drive(0, 1, 0, 5'd7, 32'h0000_010C, 32'hCAFE_F00D, 32'h0000_0200,
          mk(0, 0, 5'd7, 32'h0000_010C, 32'h0000_0200, 32'h55AA_55AA, 32'h0000_0200));
    wait_commit();
    chk("store_req_cycles", 160'(req_cnt), 160'd4);
    chk("store_stall_cycles", 160'(stall_cnt), 160'd5);
    chk("store_bus", 160'({cap_addr, cap_wdata, cap_we}), 160'({32'h0000_0200, 32'hCAFE_F00D, 1'b1}));
    chk("store_buserr_clear", 160'(BusErr), 160'd0);

    // Load that never gets acked: abandoned after TIMEOUT=4 request cycles.
    ack_en = 0; ack_wait = 0;
    drive(1, 0, 1, 5'd8, 32'h0000_0110, 32'h0, 32'h0000_0300,
          mk(1, 1, 5'd8, 32'h0000_0110, 32'h0000_0300, 32'h0, 32'h0));
    wait_commit();
    chk("timeout_req_cycles", 160'(req_cnt), 160'd4);
    chk("timeout_buserr", 160'(BusErr), 160'd1);

    // Following load completes normally; BusErr stays set.
    ack_en = 1; rd_val = 32'h1357_9BDF;
    drive(1, 0, 1, 5'd9, 32'h0000_0114, 32'h0, 32'h0000_0304,
          mk(1, 1, 5'd9, 32'h0000_0114, 32'h0000_0304, 32'h1357_9BDF, 32'h1357_9BDF));
    wait_commit();
    chk("after_timeout_req_cycles", 160'(req_cnt), 160'd1);
    chk("buserr_sticky", 160'(BusErr), 160'd1);

    // Two back-to-back loads.
    rd_val = 32'h1111_1111;
    drive(1, 0, 1, 5'd3, 32'h0000_0118, 32'h0, 32'h0000_0400,
          mk(1, 1, 5'd3, 32'h0000_0118, 32'h0000_0400, 32'h1111_1111, 32'h1111_1111));
    wait_commit();
    rd_val = 32'h2222_2222;
    RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; RD_M = 5'd4;
    PCPlus4M = 32'h0000_011C; WriteDataM = 32'h0; ALU_ResultM = 32'h0000_0404;
    sb_q.push_back(mk(1, 1, 5'd4, 32'h0000_011C, 32'h0000_0404, 32'h2222_2222, 32'h2222_2222));
    wait_commit();
    pat = 32'd0;
    for (int i = 0; i < 5; i++) pat = {pat[30:0], (i < req_hist.size()) ? req_hist[i] : 1'b1};
    chk("b2b_req_pattern", 160'(pat), 160'(5'b01001));

    // Reset asserted while the request is outstanding.
    ack_en = 0; rd_val = 32'h0F0F_0F0F;
    drive(1, 0, 1, 5'd10, 32'h0000_0120, 32'h0, 32'h0000_0500,
          mk(1, 1, 5'd10, 32'h0000_0120, 32'h0000_0500, 32'h0F0F_0F0F, 32'h0F0F_0F0F));
    begin
      int n = 0;
      while (!mem_req && n < 10) begin
        @(posedge clk); #3; n++;
      end
    end
    chk("rst_pre_req", 160'(mem_req), 160'd1);
    rst = 1'b0;
    #1;
    chk("rst_req_drop", 160'(mem_req), 160'd0);
    chk("rst_w_clear", 160'(w_actual()), 160'd0);
    chk("rst_buserr_stall", 160'({BusErr, StallM}), 160'({1'b0, 1'b1}));
    ack_en = 1;
    @(posedge clk); #3;
    rst = 1'b1;
    req_cnt = 0;
    wait_commit();
    chk("rst_reissue_req_cycles", 160'(req_cnt), 160'd1);

    // Drain: idle inputs, stop monitoring after the last write is compared.
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = 0;
    PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0;
    mon_en = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 160'(sb_q.size()), 160'd0);
    chk("bus_stable", 160'(unstable), 160'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
